// File: rtl/vga_rx_pkg.sv
// Shared timing defaults, PMOD bit map and FSM state type for the VGA PMOD
// receiver.
package vga_rx_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL     = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL     = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;

  localparam int PMOD_R1 = 0;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_VS = 3;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_HS = 7;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} rx_state_e;

  typedef struct packed {
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
  } rgb_t;

  // Bit 1 of each channel is the MSB (R1/G1/B1).
  function automatic rgb_t pmod_rgb(input logic [7:0] bus);
    rgb_t c;
    c.red   = {bus[PMOD_R1], bus[PMOD_R0]};
    c.green = {bus[PMOD_G1], bus[PMOD_G0]};
    c.blue  = {bus[PMOD_B1], bus[PMOD_B0]};
    return c;
  endfunction
endpackage

// File: rtl/vga_pmod_receiver_sync_edge_detect.sv
// Polarity-normalised sync level plus inactive->active edge pulse.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic level,
  output logic assert_pulse
);
  logic level_q;

  assign level        = sync_in ^ ACTIVE_LOW;
  assign assert_pulse = level & ~level_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
endmodule

// File: rtl/vga_pmod_receiver.sv
// TinyVGA PMOD receiver: locks onto sync timing and recovers pixel x/y/colour,
// with timing-error detection and a locked-frame counter.
module vga_pmod_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  output logic       pixel_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_error,
  output logic [7:0] frame_count
);
  localparam int LINE_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LN = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HT_LAST = 10'(LINE_LEN - 1);
  localparam logic [9:0] HT_SAT  = 10'(LINE_LEN);
  localparam logic [9:0] VT_LAST = 10'(FRAME_LN - 1);
  localparam logic [9:0] VT_SAT  = 10'(FRAME_LN);
  localparam logic [9:0] HA_LO   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA_HI   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VA_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA_HI   = 10'(V_SYNC + V_BP + V_ACTIVE);

  // Reset the input register to "both syncs inactive" so release is edge-free.
  localparam logic [7:0] SYNC_MASK = 8'((1 << PMOD_HS) | (1 << PMOD_VS));
  localparam logic [7:0] VGA_IDLE  = SYNC_ACTIVE_LOW ? SYNC_MASK : 8'h00;

  logic [7:0] vga_q;
  logic [1:0] sync_raw, sync_lvl, sync_pulse;   // [1] hsync, [0] vsync
  logic       unused_lvl;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vga_q <= VGA_IDLE;
    else        vga_q <= vga_in;

  assign sync_raw   = {vga_q[PMOD_HS], vga_q[PMOD_VS]};
  assign unused_lvl = ^sync_lvl;

  for (genvar i = 0; i < 2; i++) begin : g_sync
    sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_sync (
      .clk          (clk),
      .rst_n        (rst_n),
      .sync_in      (sync_raw[i]),
      .level        (sync_lvl[i]),
      .assert_pulse (sync_pulse[i])
    );
  end

  rx_state_e  state;
  logic [9:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
  logic       vs_seen, hs_edge, vs_mark, frame_bnd, err, lock_nx, act;
  rgb_t       pix;

  assign hs_edge   = sync_pulse[1];
  assign vs_mark   = vs_seen | sync_pulse[0];
  assign frame_bnd = hs_edge & vs_mark;
  assign pix       = pmod_rgb(vga_q);

  // *_nx counters give the position of the sample currently held in vga_q.
  always_comb begin
    hcnt_nx = hs_edge ? 10'd0 : (hcnt == HT_SAT ? HT_SAT : hcnt + 10'd1);
    vcnt_nx = vcnt;
    if (hs_edge) vcnt_nx = vs_mark ? 10'd0 : (vcnt == VT_SAT ? VT_SAT : vcnt + 10'd1);
    err = (state != HUNT) &&
          (( hs_edge && hcnt != HT_LAST) ||
           (!hs_edge && hcnt == HT_LAST) ||
           ( hs_edge &&  vs_mark && vcnt != VT_LAST) ||
           ( hs_edge && !vs_mark && vcnt == VT_LAST));
    lock_nx = !err && ((state == LOCKED) || (state == CHECK && frame_bnd));
    act = lock_nx && hcnt_nx >= HA_LO && hcnt_nx < HA_HI &&
          vcnt_nx >= VA_LO && vcnt_nx < VA_HI;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= HUNT;
      hcnt         <= '0;
      vcnt         <= '0;
      vs_seen      <= 1'b0;
      pixel_valid  <= 1'b0;
      x            <= '0;
      y            <= '0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
      frame_count  <= '0;
    end else begin
      hcnt    <= hcnt_nx;
      vcnt    <= vcnt_nx;
      vs_seen <= hs_edge ? 1'b0 : vs_mark;
      case (state)
        HUNT:    if (frame_bnd) state <= CHECK;
        CHECK:   if (err) state <= HUNT;
                 else if (frame_bnd) state <= LOCKED;
        LOCKED:  if (err) state <= HUNT;
                 else if (frame_bnd) frame_count <= frame_count + 8'd1;
        default: state <= HUNT;
      endcase
      locked       <= lock_nx;
      timing_error <= err;
      pixel_valid  <= act;
      x            <= act ? hcnt_nx - HA_LO : 10'd0;
      y            <= act ? vcnt_nx - VA_LO : 10'd0;
      red          <= act ? pix.red   : 2'b00;
      green        <= act ? pix.green : 2'b00;
      blue         <= act ? pix.blue  : 2'b00;
      frame_start  <= act && hcnt_nx == HA_LO && vcnt_nx == VA_LO;
    end
endmodule

// File: tb/tb_vga_pmod_receiver.sv
// Directed bench: shrunken VGA timing generator driving the receiver through
// lock, pixel recovery, short line, missing vsync, async reset and count wrap.
module tb_vga_pmod_receiver;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int LL = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 9
  localparam int HA0 = HS + HB;            // 5
  localparam int VA0 = VS + VB;            // 4

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] vga_in = 8'h88;
  logic       pixel_valid, frame_start, locked, timing_error;
  logic [9:0] x, y;
  logic [1:0] red, green, blue;
  logic [7:0] frame_count;

  vga_pmod_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
    .pixel_valid(pixel_valid), .x(x), .y(y),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .locked(locked),
    .timing_error(timing_error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         h, v;
    logic       act, fs;
    logic [9:0] ex, ey;
    logic [1:0] r, g, b;
  } pix_t;

  int   n_vec = 0, n_miss = 0;
  int   gh = 0, gv = 5, short_v = -1;
  bit   vs_sup = 0, vs_early = 0, chk_en = 0;
  pix_t p1, p2;
  int   o_h = -1, o_v = -1;
  logic o_valid;
  logic [9:0] o_x, o_y;
  int   n_valid = 0, n_fs = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: observe outputs for the sample driven two clocks ago,
  // then drive the next generator sample.
  task automatic step();
    logic hs, vs, act;
    logic [9:0] ex, ey;
    logic [1:0] r, g, b;
    int len;
    @(negedge clk);
    o_h = p2.h; o_v = p2.v; o_valid = pixel_valid; o_x = x; o_y = y;
    n_valid += int'(pixel_valid);
    n_fs    += int'(frame_start);
    n_err   += int'(timing_error);
    if (chk_en)
      chk($sformatf("pix(%0d,%0d)", p2.h, p2.v),
          {34'd0, locked, timing_error, pixel_valid, frame_start, x, y, red, green, blue},
          {34'd0, 2'b10, p2.act, p2.fs, p2.ex, p2.ey, p2.r, p2.g, p2.b});
    hs  = gh < HS;
    vs  = !vs_sup && (gv < VS || (vs_early && gv == VT - 1 && gh >= 7));
    act = gh >= HA0 && gh < HA0 + HA && gv >= VA0 && gv < VA0 + VA;
    ex  = act ? 10'(gh - HA0) : 10'd0;
    ey  = act ? 10'(gv - VA0) : 10'd0;
    r   = act ? ex[1:0] : 2'b00;
    g   = act ? ey[1:0] : 2'b00;
    b   = act ? 2'b10   : 2'b00;
    vga_in = {~hs, b[0], g[0], r[0], ~vs, b[1], g[1], r[1]};
    p2 = p1;
    p1 = '{h: gh, v: gv, act: act, fs: act && ex == 0 && ey == 0,
           ex: ex, ey: ey, r: r, g: g, b: b};
    len = (gv == short_v) ? LL - 1 : LL;
    gh++;
    if (gh >= len) begin
      gh = 0;
      if (gv == short_v) short_v = -1;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end
  endtask

  // Step until the observed outputs belong to generator sample (h,v).
  task automatic look(input int h, input int v);
    int k = 0;
    do begin step(); k++; end while (!(o_h == h && o_v == v) && k < 3 * LL * VT);
    chk($sformatf("reach(%0d,%0d)", h, v), 64'(o_h == h && o_v == v), 64'd1);
  endtask

  initial begin
    p1 = '{h: -1, v: -1, default: '0};
    p2 = p1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {20'd0, pixel_valid, x, y, red, green, blue, frame_start,
                       locked, timing_error, frame_count}, 64'd0);
    rst_n = 1'b1;

    // Acquisition: first vsync boundary -> CHECK, second -> LOCKED.
    look(0, 0); chk("lock_1st_vs", 64'(locked), 64'd0);
    look(14, 8); chk("lock_pre_2nd", 64'(locked), 64'd0);
    look(0, 0);
    chk("lock_2nd_vs", {61'd0, locked, timing_error, pixel_valid}, {61'd0, 3'b100});
    chk("fc_at_lock", 64'(frame_count), 64'd0);

    // One full locked frame with per-pixel checking.
    n_valid = 0; n_fs = 0; n_err = 0; chk_en = 1;
    look(0, 0);
    chk_en = 0;
    chk("valid_cnt", 64'(n_valid), 64'(HA * VA));
    chk("fs_cnt", 64'(n_fs), 64'd1);
    chk("err_cnt_clean", 64'(n_err), 64'd0);
    chk("fc_one", 64'(frame_count), 64'd1);

    // Short line at row 5 (active line 1).
    n_err = 0; short_v = 5;
    look(13, 5); chk("short_pre", {62'd0, locked, timing_error}, {62'd0, 2'b10});
    look(0, 6);
    chk("short_err", {61'd0, timing_error, locked, pixel_valid}, {61'd0, 3'b100});
    look(0, 0); chk("short_relock_chk", 64'(locked), 64'd0);
    look(0, 0); chk("short_relock", 64'(locked), 64'd1);
    chk("short_err_once", 64'(n_err), 64'd1);
    chk("short_fc_hold", 64'(frame_count), 64'd1);

    // Suppress one vsync while locked.
    n_err = 0; vs_sup = 1;
    look(0, 0);
    chk("novs_err", {62'd0, timing_error, locked}, {62'd0, 2'b10});
    chk("novs_fc_hold", 64'(frame_count), 64'd1);
    look(0, 3); vs_sup = 0;
    look(0, 0); chk("novs_relock_chk", 64'(locked), 64'd0);
    look(0, 0); chk("novs_relock", 64'(locked), 64'd1);
    chk("novs_err_once", 64'(n_err), 64'd1);

    // Async reset in the middle of an active line (x=3, y=2).
    look(8, 6);
    chk("rst_pre_pix", {43'd0, o_valid, o_x, o_y}, {43'd0, 1'b1, 10'd3, 10'd2});
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", {20'd0, pixel_valid, x, y, red, green, blue, frame_start,
                              locked, timing_error, frame_count}, 64'd0);
    n_err = 0;
    repeat (3) step();
    rst_n = 1'b1;
    look(0, 0); chk("rst_relock_chk", 64'(locked), 64'd0);
    look(0, 0); chk("rst_relock", 64'(locked), 64'd1);
    chk("rst_fc_zero", 64'(frame_count), 64'd0);
    chk("rst_no_err", 64'(n_err), 64'd0);

    // Frame count wrap, with vsync now asserting mid-line before the boundary.
    vs_early = 1; chk_en = 1;
    for (int i = 0; i < 255; i++) look(0, 0);
    chk("fc_255", 64'(frame_count), 64'd255);
    look(0, 0);
    chk("fc_wrap", 64'(frame_count), 64'd0);
    chk("wrap_locked", 64'(locked), 64'd1);
    chk("wrap_no_err", 64'(n_err), 64'd0);
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_pmod_receiver.md
# vga_pmod_receiver

Receive-side counterpart of the game's TinyVGA PMOD output: samples the 8-bit PMOD bus (2-bit RGB plus hsync/vsync), locks onto 640x480@60 timing, and recovers per-pixel coordinates and colour. It serves as the loopback checker and capture front-end for the sea-battle VGA path. It runs one pixel per `clk` in the pixel-clock domain of the generator.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal porches and sync, in clocks; `H_TOTAL` = sum = 800
- `V_ACTIVE`, 480: active lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical porches and sync, in lines; `V_TOTAL` = 525
- `SYNC_ACTIVE_LOW`, 1: sync polarity
- `clk`  in  1  pixel clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `vga_in`  in  8  PMOD bus: [0] R1, [1] G1, [2] B1, [3] vsync, [4] R0, [5] G0, [6] B0, [7] hsync
- `pixel_valid`  out  1  current outputs are an active pixel of a locked frame
- `x`  out  10  column 0..639; 0 when `pixel_valid` = 0
- `y`  out  10  row 0..479; 0 when `pixel_valid` = 0
- `red`, `green`, `blue`  out  2 each  pixel colour; 0 when `pixel_valid` = 0
- `frame_start`  out  1  one-cycle pulse coincident with `pixel_valid` at x = 0, y = 0
- `locked`  out  1  FSM in LOCKED
- `timing_error`  out  1  one-cycle pulse on any timing violation while in CHECK or LOCKED
- `frame_count`  out  8  completed locked frames; wraps 255 -> 0

## Operation
- **Input stage.** `vga_in` is registered once. Sync bits are normalised to active-high using `SYNC_ACTIVE_LOW`. Assert edges (inactive -> active) are detected against the previous registered value.
- **Horizontal counter (`hcnt`).**
  - Cleared to 0 on the hsync-assert-edge cycle; otherwise increments.
  - Saturates at `H_TOTAL` in HUNT.
  - Active window: `hcnt` in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), i.e. 144..783. x = hcnt - 144.
- **Vertical counter (`vcnt`).**
  - A `vs_seen` flag is set by a vsync assert edge, including one in the same cycle as an hsync edge.
  - On each hsync edge: if `vs_seen`, then `vcnt` <= 0 and the flag is cleared; otherwise `vcnt` increments.
  - Active lines: 35..514. y = vcnt - 35.
- **Errors** (flagged in CHECK or LOCKED only):
  - An hsync edge with `hcnt` != H_TOTAL-1.
  - `hcnt` reaching H_TOTAL-1 with no hsync edge on the next cycle.
  - A line boundary with `vs_seen` and `vcnt` != V_TOTAL-1.
  - A line boundary without `vs_seen` when `vcnt` = V_TOTAL-1.
- **FSM.**
  - HUNT: no errors are reported. Go to CHECK on the first line boundary with `vs_seen`.
  - CHECK: any error pulses `timing_error` and returns to HUNT. The next `vs_seen` line boundary with no error goes to LOCKED (one full verified frame).
  - LOCKED: any error pulses `timing_error` and returns to HUNT. `locked` drops on the same cycle `timing_error` pulses.
- **Frame count.** `frame_count` increments on each `vs_seen` line boundary in LOCKED that has no error.
- **Simultaneous events.** An error and a lock transition in the same cycle resolve as the error (go to HUNT). When hsync and vsync edges coincide, the line boundary is treated as vsync-marked.

## Timing
- Latency from `vga_in` to `pixel_valid`/`x`/`y`/colour is 2 clocks: input register, then output register.
- All outputs are registered.
- Reset is asynchronous. It clears the FSM to HUNT, all counters and flags, and all outputs to 0.
- Reset mid-frame drops `locked` and `pixel_valid` immediately, with no error pulse. Relock requires one full clean frame after the next vsync.
- With a perfect source, `locked` rises at the second vsync-marked line boundary after reset release. The first `frame_start` follows 35 lines + 144 clocks + 2 clocks after that boundary's hsync edge at the pins.

## Structure
- Package `vga_rx_pkg`:
  - Timing defaults and derived constants: H_TOTAL, V_TOTAL, H_ACT_START = 144, V_ACT_START = 35.
  - PMOD bit-index constants.
  - FSM state enum: HUNT, CHECK, LOCKED.
- One sub-module, `sync_edge_detect`, instantiated twice (hsync, vsync). It normalises polarity and outputs `level` and `assert_pulse`.

## Test plan
- Ideal 640x480 generator from reset: `locked` rises at the 2nd vsync boundary. Next frame: exactly 307200 `pixel_valid` cycles, `frame_start` once, x/y run 0..639/0..479.
- Colour integrity: drive R = x[1:0], G = y[1:0], B = 2'b10 during active video. Every valid output matches the same function of the reported x/y. Colour is 0 outside active video.
- Short line: once locked, one line of 799 clocks -> `timing_error` pulses once, `locked` = 0 the same cycle, `pixel_valid` = 0. Relock after one clean frame.
- Missing vsync: in LOCKED, suppress one vsync -> error when `vcnt` = 524 passes without a mark. `frame_count` holds its value.
- Async reset: assert `rst_n` = 0 at y = 200, x = 300 -> all outputs 0 within the reset cycle, no error pulse. Relock takes 2 vsyncs.
- `frame_count` wrap: run 256 locked frames -> count reads 255, then 0. Coincident hsync/vsync edges still lock.
